qracc_sram_seq: RTL and testbench

//  Digital initiator for the banked QRAcc SRAM port (bank_select/PCH/WL/WRITE/WR_DATA/CSEL/SAEN/SA_OUT).

---
 rtl/qracc_sram_seq.sv | 209 ++++++++++++++++++++
 tb/tb_qracc_sram_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qracc_sram_seq.sv
// qracc_sram_seq: valid/ready row request sequencer driving the banked QRAcc SRAM port.
// Optional write read-back verify is enabled by defining QRACC_WRITE_VERIFY_EN.
module qracc_sram_seq #(
    parameter int numRows   = 128,
    parameter int numCols   = 8,
    parameter int numBanks  = 8,
    parameter int pchCycles = 2,
    parameter int wlCycles  = 2
) (
    input  logic                        CLK,
    input  logic                        nRESET,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [$clog2(numBanks)-1:0] req_bank,
    input  logic [$clog2(numRows)-1:0]  req_row,
    input  logic [numCols-1:0]          req_wdata,
    input  logic [numCols-1:0]          req_mask,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [numCols-1:0]          rsp_data,
    output logic                        rsp_err,
    output logic [numBanks-1:0]         bank_select,
    output logic                        PCH,
    output logic [numRows-1:0]          WL,
    output logic                        WRITE,
    output logic [numCols-1:0]          WR_DATA,
    output logic [numCols-1:0]          CSEL,
    output logic                        SAEN,
    input  logic [numCols-1:0]          SA_OUT
);
    localparam int BW   = $clog2(numBanks);
    localparam int RW   = $clog2(numRows);
    localparam int CMAX = (pchCycles > wlCycles) ? pchCycles : wlCycles;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] CNT_P = CW'(pchCycles - 1);
    localparam logic [CW-1:0] CNT_W = CW'(wlCycles - 1);

    // state   | meaning
    // S_IDLE  | req_ready high, waiting for a request
    // S_PCH   | precharge strobe, pchCycles long
    // S_WL    | wordline (plus WRITE on the write pass), wlCycles long
    // S_SENSE | wordline held, sense-amp strobe, SA_OUT captured at exit
    // S_RESP  | response held until rsp_ready
    // S_GAP   | one quiet cycle between a write and its verify read
    typedef enum logic [2:0] {
        S_IDLE, S_PCH, S_WL, S_SENSE, S_RESP, S_GAP
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CW-1:0]       r_cnt, w_cnt_nxt;
    logic                r_vphase, w_vphase_nxt;
    logic                w_accept, w_bank_oor;

    logic                r_write;
    logic [BW-1:0]       r_bank;
    logic [RW-1:0]       r_row;
    logic [numCols-1:0]  r_wdata, r_mask;

    logic                w_write;
    logic [BW-1:0]       w_bank;
    logic [RW-1:0]       w_row;
    logic [numCols-1:0]  w_wdata, w_mask;
    logic [numBanks-1:0] w_bank_oh;
    logic [numRows-1:0]  w_row_oh;
    logic                w_wr_pass, w_arr_on, w_verify_err;

    logic                r_req_ready, r_rsp_valid, r_rsp_err;
    logic [numCols-1:0]  r_rsp_data;
    logic [numBanks-1:0] r_bank_sel;
    logic                r_pch, r_write_o, r_saen;
    logic [numRows-1:0]  r_wl;
    logic [numCols-1:0]  r_wr_data, r_csel;

    assign w_bank_oor   = (int'(req_bank) >= numBanks);
    assign w_verify_err = |((SA_OUT ^ r_wdata) & r_mask);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_vphase_nxt = r_vphase;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_vphase_nxt = 1'b0;
                    if (w_bank_oor) begin
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_PCH;
                        w_cnt_nxt   = CNT_P;
                    end
                end
            end
            S_PCH: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_WL;
                    w_cnt_nxt   = CNT_W;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_WL: begin
                if (r_cnt == '0) begin
                    if (!r_write || r_vphase) begin
                        w_state_nxt = S_SENSE;
                    end else begin
`ifdef QRACC_WRITE_VERIFY_EN
                        w_state_nxt = S_GAP;
`else
                        w_state_nxt = S_IDLE;
`endif
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_GAP: begin
                w_state_nxt  = S_PCH;
                w_cnt_nxt    = CNT_P;
                w_vphase_nxt = 1'b1;
            end
            S_SENSE: w_state_nxt = S_RESP;
            S_RESP: begin
                if (rsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so on the accept edge the fresh request fields are used.
    always_comb begin
        w_write   = w_accept ? req_write : r_write;
        w_bank    = w_accept ? req_bank  : r_bank;
        w_row     = w_accept ? req_row   : r_row;
        w_wdata   = w_accept ? req_wdata : r_wdata;
        w_mask    = w_accept ? req_mask  : r_mask;
        w_wr_pass = w_write & ~w_vphase_nxt;
        w_arr_on  = (w_state_nxt == S_PCH) || (w_state_nxt == S_WL) || (w_state_nxt == S_SENSE);
        w_bank_oh = '0;
        for (int i = 0; i < numBanks; i++) w_bank_oh[i] = (int'(w_bank) == i);
        w_row_oh = '0;
        for (int i = 0; i < numRows; i++) w_row_oh[i] = (int'(w_row) == i);
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_vphase    <= 1'b0;
            r_write     <= 1'b0;
            r_bank      <= '0;
            r_row       <= '0;
            r_wdata     <= '0;
            r_mask      <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            r_bank_sel  <= '0;
            r_pch       <= 1'b0;
            r_wl        <= '0;
            r_write_o   <= 1'b0;
            r_wr_data   <= '0;
            r_csel      <= '0;
            r_saen      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_vphase <= w_vphase_nxt;
            if (w_accept) begin
                r_write <= req_write;
                r_bank  <= req_bank;
                r_row   <= req_row;
                r_wdata <= req_wdata;
                r_mask  <= req_mask;
            end
            r_req_ready <= (w_state_nxt == S_IDLE);
            r_rsp_valid <= (w_state_nxt == S_RESP);
            r_bank_sel  <= w_arr_on ? w_bank_oh : '0;
            r_pch       <= (w_state_nxt == S_PCH);
            r_wl        <= ((w_state_nxt == S_WL) || (w_state_nxt == S_SENSE)) ? w_row_oh : '0;
            r_write_o   <= (w_state_nxt == S_WL) && w_wr_pass;
            r_wr_data   <= ((w_state_nxt == S_WL) && w_wr_pass) ? w_wdata : '0;
            r_csel      <= ((w_state_nxt == S_WL) || (w_arr_on && !w_wr_pass)) ? w_mask : '0;
            r_saen      <= (w_state_nxt == S_SENSE);
            if (w_accept && w_bank_oor) begin
                r_rsp_data <= '0;
                r_rsp_err  <= 1'b1;
            end else if (r_state == S_SENSE) begin
                r_rsp_data <= SA_OUT;
                r_rsp_err  <= r_vphase & w_verify_err;
            end
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_err     = r_rsp_err;
    assign bank_select = r_bank_sel;
    assign PCH         = r_pch;
    assign WL          = r_wl;
    assign WRITE       = r_write_o;
    assign WR_DATA     = r_wr_data;
    assign CSEL        = r_csel;
    assign SAEN        = r_saen;
endmodule

// File: tb/tb_qracc_sram_seq.sv
// Directed bench for qracc_sram_seq; the verify scenario is compiled in when QRACC_WRITE_VERIFY_EN is defined.
module tb_qracc_sram_seq;
    logic         CLK, nRESET;
    logic         req_valid, req_write, rsp_ready;
    logic [2:0]   req_bank;
    logic [6:0]   req_row;
    logic [7:0]   req_wdata, req_mask, sa_val;
    logic         req_ready, rsp_valid, rsp_err, PCH, WRITE, SAEN;
    logic [7:0]   rsp_data, bank_select, WR_DATA, CSEL, SA_OUT;
    logic [127:0] WL;

    logic         b_req_valid, b_rsp_ready;
    logic         b_req_ready, b_rsp_valid, b_rsp_err, b_PCH, b_WRITE, b_SAEN;
    logic [7:0]   b_rsp_data, b_WR_DATA, b_CSEL, b_SA_OUT;
    logic [5:0]   b_bank_select;
    logic [127:0] b_WL;

    int n_vec = 0;
    int n_err = 0;

    assign SA_OUT   = SAEN   ? sa_val : 8'h00;
    assign b_SA_OUT = b_SAEN ? sa_val : 8'h00;

    qracc_sram_seq u_dut (
        .CLK(CLK), .nRESET(nRESET), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_bank(req_bank), .req_row(req_row), .req_wdata(req_wdata),
        .req_mask(req_mask), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .bank_select(bank_select), .PCH(PCH), .WL(WL), .WRITE(WRITE),
        .WR_DATA(WR_DATA), .CSEL(CSEL), .SAEN(SAEN), .SA_OUT(SA_OUT)
    );

    qracc_sram_seq #(.numBanks(6)) u_dut_b (
        .CLK(CLK), .nRESET(nRESET), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_write(req_write), .req_bank(req_bank), .req_row(req_row), .req_wdata(req_wdata),
        .req_mask(req_mask), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
        .rsp_err(b_rsp_err), .bank_select(b_bank_select), .PCH(b_PCH), .WL(b_WL), .WRITE(b_WRITE),
        .WR_DATA(b_WR_DATA), .CSEL(b_CSEL), .SAEN(b_SAEN), .SA_OUT(b_SA_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Returns in cycle 1 of the accepted request.
    task automatic issue(input logic wr, input logic [2:0] bk, input logic [6:0] rw,
                         input logic [7:0] wd, input logic [7:0] mk);
        req_write = wr; req_bank = bk; req_row = rw; req_wdata = wd; req_mask = mk;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic seen;
        nRESET = 1'b0;
        repeat (3) step();
        n_vec++;
        if ({rsp_valid, rsp_err, rsp_data, PCH, SAEN, WRITE, bank_select, WL, CSEL, WR_DATA} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got bsel=%h wl=%h pch=%b rspv=%b, want all 0", bank_select, WL, PCH, rsp_valid);
        end
        n_vec++;
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        nRESET = 1'b1;
        step();
        sa_val = 8'h77;
        issue(1'b0, 3'd3, 7'd5, 8'h00, 8'hFF);
        step(); step();
        n_vec++;
        if (WL !== (128'd1 << 5)) begin n_err++; $display("FAIL midreset_pre_wl: got %h want WL[5]", WL); end
        nRESET = 1'b0;
        step();
        n_vec++;
        if ({PCH, WL, SAEN, WRITE, bank_select, rsp_valid} !== '0) begin
            n_err++;
            $display("FAIL midreset_strobes: got pch=%b wl=%h saen=%b bsel=%h rspv=%b want 0", PCH, WL, SAEN, bank_select, rsp_valid);
        end
        n_vec++;
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL midreset_ready: got %b want 1", req_ready); end
        step(); step();
        nRESET = 1'b1;
        seen = 1'b0;
        repeat (8) begin step(); seen = seen | rsp_valid | PCH | SAEN; end
        n_vec++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL midreset_no_resume: got activity=%b want 0", seen); end
    endtask

    task automatic test_write();
        sa_val = 8'hA5;
        rsp_ready = 1'b0;
        issue(1'b1, 3'd3, 7'd5, 8'hA5, 8'hFF);
        for (int c = 1; c <= 4; c++) begin
            logic wlc;
            wlc = (c >= 3);
            n_vec++;
            if (bank_select !== 8'h08) begin n_err++; $display("FAIL wr_bsel c%0d: got %h want 08", c, bank_select); end
            n_vec++;
            if (PCH !== (c <= 2)) begin n_err++; $display("FAIL wr_pch c%0d: got %b", c, PCH); end
            n_vec++;
            if (WL !== (wlc ? (128'd1 << 5) : 128'd0)) begin n_err++; $display("FAIL wr_wl c%0d: got %h", c, WL); end
            n_vec++;
            if ({WRITE, WR_DATA, CSEL} !== (wlc ? {1'b1, 8'hA5, 8'hFF} : 17'd0)) begin
                n_err++; $display("FAIL wr_strobe c%0d: got write=%b data=%h csel=%h", c, WRITE, WR_DATA, CSEL);
            end
            n_vec++;
            if (req_ready !== 1'b0) begin n_err++; $display("FAIL wr_busy c%0d: got ready %b want 0", c, req_ready); end
            step();
        end
`ifdef QRACC_WRITE_VERIFY_EN
        for (int c = 5; c <= 11; c++) begin
            n_vec++;
            if (rsp_valid !== (c == 11)) begin n_err++; $display("FAIL wrv_rspv c%0d: got %b", c, rsp_valid); end
            if (c < 11) step();
        end
        n_vec++;
        if ({rsp_data, rsp_err} !== {8'hA5, 1'b0}) begin n_err++; $display("FAIL wrv_rsp: got %h/%b want a5/0", rsp_data, rsp_err); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
`else
        n_vec++;
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready_c5: got %b want 1", req_ready); end
        n_vec++;
        if ({PCH, WL, WRITE, SAEN, bank_select} !== '0) begin n_err++; $display("FAIL wr_c5_quiet: got wl=%h bsel=%h", WL, bank_select); end
        step(); step();
        n_vec++;
        if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_no_rsp: got %b want 0", rsp_valid); end
`endif
    endtask

    task automatic test_read();
        sa_val = 8'hA5;
        rsp_ready = 1'b0;
        issue(1'b0, 3'd3, 7'd5, 8'h00, 8'hFF);
        for (int c = 1; c <= 6; c++) begin
            logic act;
            act = (c <= 5);
            n_vec++;
            if (SAEN !== (c == 5)) begin n_err++; $display("FAIL rd_saen c%0d: got %b", c, SAEN); end
            n_vec++;
            if (PCH !== (c <= 2)) begin n_err++; $display("FAIL rd_pch c%0d: got %b", c, PCH); end
            n_vec++;
            if (WL !== ((c >= 3 && c <= 5) ? (128'd1 << 5) : 128'd0)) begin n_err++; $display("FAIL rd_wl c%0d: got %h", c, WL); end
            n_vec++;
            if ({bank_select, CSEL} !== (act ? 16'h08FF : 16'h0000)) begin
                n_err++; $display("FAIL rd_bsel_csel c%0d: got %h/%h", c, bank_select, CSEL);
            end
            n_vec++;
            if ({rsp_valid, WRITE, req_ready} !== {(c == 6), 2'b00}) begin
                n_err++; $display("FAIL rd_ctl c%0d: got rspv=%b write=%b ready=%b", c, rsp_valid, WRITE, req_ready);
            end
            n_vec++;
            if ((PCH && (WL != '0)) || (SAEN && WRITE)) begin n_err++; $display("FAIL rd_invariant c%0d: got overlap", c); end
            if (c < 6) step();
        end
        n_vec++;
        if ({rsp_data, rsp_err} !== {8'hA5, 1'b0}) begin n_err++; $display("FAIL rd_rsp: got %h/%b want a5/0", rsp_data, rsp_err); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_vec++;
        if ({rsp_valid, req_ready} !== 2'b01) begin n_err++; $display("FAIL rd_done: got rspv=%b ready=%b", rsp_valid, req_ready); end
    endtask

    task automatic test_stall();
        logic seen;
        sa_val = 8'h3C;
        rsp_ready = 1'b0;
        issue(1'b0, 3'd1, 7'd127, 8'h00, 8'h0F);
        repeat (5) step();
        sa_val = 8'hFF;
        req_write = 1'b0; req_bank = 3'd2; req_row = 7'd0; req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({rsp_valid, rsp_data, rsp_err, req_ready, PCH} !== {1'b1, 8'h3C, 1'b0, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL stall_hold %0d: got v=%b d=%h e=%b rdy=%b pch=%b want 1/3c/0/0/0", i, rsp_valid, rsp_data, rsp_err, req_ready, PCH);
            end
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_vec++;
        if ({rsp_valid, req_ready} !== 2'b01) begin n_err++; $display("FAIL stall_release: got rspv=%b ready=%b", rsp_valid, req_ready); end
        seen = 1'b0;
        repeat (3) begin step(); seen = seen | PCH | (bank_select != 0); end
        n_vec++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL stall_not_latched: got activity=%b want 0", seen); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int exp_cyc;
`ifdef QRACC_WRITE_VERIFY_EN
        exp_cyc = 12;
`else
        exp_cyc = 5;
`endif
        sa_val = 8'h5A;
        rsp_ready = 1'b1;
        issue(1'b1, 3'd0, 7'd0, 8'h5A, 8'h0F);
        cyc = 1;
        while (!req_ready && cyc < 20) begin step(); cyc++; end
        n_vec++;
        if (cyc !== exp_cyc) begin n_err++; $display("FAIL b2b_ready_cycle: got %0d want %0d", cyc, exp_cyc); end
        issue(1'b0, 3'd7, 7'd127, 8'h00, 8'hFF);
        n_vec++;
        if ({bank_select, PCH} !== {8'h80, 1'b1}) begin n_err++; $display("FAIL b2b_bsel: got %h/%b want 80/1", bank_select, PCH); end
        step(); step();
        n_vec++;
        if (WL !== (128'd1 << 127)) begin n_err++; $display("FAIL b2b_wl: got %h want WL[127]", WL); end
        repeat (3) step();
        n_vec++;
        if ({rsp_valid, rsp_data} !== {1'b1, 8'h5A}) begin n_err++; $display("FAIL b2b_rsp: got %b/%h want 1/5a", rsp_valid, rsp_data); end
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_oob();
        for (int k = 0; k < 2; k++) begin
            req_write = (k == 1); req_bank = (k == 0) ? 3'd7 : 3'd6; req_row = 7'd3;
            req_wdata = 8'hFF; req_mask = 8'hFF;
            b_req_valid = 1'b1;
            step();
            b_req_valid = 1'b0;
            n_vec++;
            if ({b_rsp_valid, b_rsp_err, b_rsp_data} !== {1'b1, 1'b1, 8'h00}) begin
                n_err++; $display("FAIL oob_rsp k%0d: got v=%b e=%b d=%h want 1/1/00", k, b_rsp_valid, b_rsp_err, b_rsp_data);
            end
            n_vec++;
            if ({b_PCH, b_WL, b_SAEN, b_WRITE, b_bank_select, b_req_ready} !== '0) begin
                n_err++; $display("FAIL oob_strobes k%0d: got pch=%b bsel=%h wl=%h", k, b_PCH, b_bank_select, b_WL);
            end
            step();
            b_rsp_ready = 1'b1;
            step();
            b_rsp_ready = 1'b0;
            n_vec++;
            if ({b_rsp_valid, b_req_ready} !== 2'b01) begin n_err++; $display("FAIL oob_done k%0d: got %b%b", k, b_rsp_valid, b_req_ready); end
        end
        sa_val = 8'hC3;
        req_write = 1'b0; req_bank = 3'd5; req_row = 7'd1; req_mask = 8'h33;
        b_req_valid = 1'b1;
        step();
        b_req_valid = 1'b0;
        n_vec++;
        if (b_bank_select !== 6'b100000) begin n_err++; $display("FAIL oob_inrange_bsel: got %b want 100000", b_bank_select); end
        repeat (5) step();
        n_vec++;
        if ({b_rsp_valid, b_rsp_err, b_rsp_data} !== {1'b1, 1'b0, 8'hC3}) begin
            n_err++; $display("FAIL oob_inrange_rsp: got %b/%b/%h want 1/0/c3", b_rsp_valid, b_rsp_err, b_rsp_data);
        end
        b_rsp_ready = 1'b1;
        step();
        b_rsp_ready = 1'b0;
    endtask

`ifdef QRACC_WRITE_VERIFY_EN
    task automatic test_verify();
        sa_val = 8'h00;
        rsp_ready = 1'b0;
        issue(1'b1, 3'd2, 7'd9, 8'h01, 8'h01);
        for (int c = 1; c <= 11; c++) begin
            n_vec++;
            if ({PCH, WRITE, SAEN, rsp_valid} !== {(c <= 2 || c == 6 || c == 7), (c == 3 || c == 4), (c == 10), (c == 11)}) begin
                n_err++; $display("FAIL vfy_seq c%0d: got pch=%b wr=%b saen=%b rspv=%b", c, PCH, WRITE, SAEN, rsp_valid);
            end
            n_vec++;
            if (WL !== (((c >= 3 && c <= 4) || (c >= 8 && c <= 10)) ? (128'd1 << 9) : 128'd0)) begin
                n_err++; $display("FAIL vfy_wl c%0d: got %h", c, WL);
            end
            if (c < 11) step();
        end
        n_vec++;
        if ({rsp_data, rsp_err} !== {8'h00, 1'b1}) begin n_err++; $display("FAIL vfy_stuck: got %h/%b want 00/1", rsp_data, rsp_err); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        sa_val = 8'h01;
        issue(1'b1, 3'd2, 7'd9, 8'h81, 8'h01);
        repeat (10) step();
        n_vec++;
        if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, 8'h01, 1'b0}) begin
            n_err++; $display("FAIL vfy_masked_ok: got %b/%h/%b want 1/01/0", rsp_valid, rsp_data, rsp_err);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        nRESET = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_bank = '0; req_row = '0;
        req_wdata = '0; req_mask = '0; rsp_ready = 1'b0; sa_val = '0;
        b_req_valid = 1'b0; b_rsp_ready = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_stall();
        test_back_to_back();
        test_oob();
`ifdef QRACC_WRITE_VERIFY_EN
        test_verify();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
